// File: rtl/hazard_ctrl_v2_pkg.sv
// Shared types for the hazard controller: state encoding, per-state control vectors, CP0 tag prefix.
package hazard_ctrl_v2_pkg;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    EXC        = 3'd1,
    EXC_WAIT   = 3'd2,
    MEM_WAIT   = 3'd3,
    LOAD_USE   = 3'd4,
    ALU_WAIT   = 3'd5,
    DRAIN      = 3'd6,
    FETCH_WAIT = 3'd7
  } state_t;

  // {stall F,D,E,M,W, flush D,E,M,W}
  localparam logic [8:0] CTRL_RUN        = 9'b00000_0000;
  localparam logic [8:0] CTRL_EXC        = 9'b11111_1111;
  localparam logic [8:0] CTRL_EXC_WAIT   = 9'b11111_1110;
  localparam logic [8:0] CTRL_MEM_WAIT   = 9'b11110_0001;
  localparam logic [8:0] CTRL_LOAD_USE   = 9'b11000_0100;
  localparam logic [8:0] CTRL_ALU_WAIT   = 9'b11100_0010;
  localparam logic [8:0] CTRL_DRAIN      = 9'b11000_0100;
  localparam logic [8:0] CTRL_FETCH_WAIT = 9'b10000_1000;

  localparam logic [1:0] CP0_PREFIX = 2'b01;

  function automatic logic [8:0] ctrl_of(input state_t s);
    logic [8:0] c;
    c = CTRL_RUN;
    case (s)
      EXC:        c = CTRL_EXC;
      EXC_WAIT:   c = CTRL_EXC_WAIT;
      MEM_WAIT:   c = CTRL_MEM_WAIT;
      LOAD_USE:   c = CTRL_LOAD_USE;
      ALU_WAIT:   c = CTRL_ALU_WAIT;
      DRAIN:      c = CTRL_DRAIN;
      FETCH_WAIT: c = CTRL_FETCH_WAIT;
      default:    c = CTRL_RUN;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding select for one stage's two source operands.
// The nearer producer wins; a producer still holding a load result is never forwarded from.
module hazard_fwd_unit #(
  parameter int         REG_W    = 7,
  parameter logic [1:0] SEL_NEAR = 2'b01,
  parameter logic [1:0] SEL_FAR  = 2'b10
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] near_tag,
  input  logic             near_we,
  input  logic             near_ld,
  input  logic [REG_W-1:0] far_tag,
  input  logic             far_we,
  input  logic             far_ld,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  function automatic logic [1:0] sel(input logic [REG_W-1:0] src);
    logic [1:0] s;
    s = 2'b00;
    if (near_we && near_tag == src && src != '0 && !near_ld)
      s = SEL_NEAR;
    else if (far_we && far_tag == src && src != '0 && !far_ld)
      s = SEL_FAR;
    return s;
  endfunction

  assign fwd_a = sel(rs);
  assign fwd_b = sel(rt);

endmodule

// File: rtl/hazard_ctrl_v2.sv
// Prioritised hazard FSM with programmable post-op drain and D/E forwarding selects.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_v2
  import hazard_ctrl_v2_pkg::*;
#(
  parameter int REG_W        = 7,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exc_req,
  input  logic             if_stall,
  input  logic             mem_stall,
  input  logic             alu_busy,
  input  logic             branch_d,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] wreg_e,
  input  logic [REG_W-1:0] wreg_m,
  input  logic [REG_W-1:0] wreg_w,
  input  logic             regwrite_e,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             memread_e,
  input  logic             memread_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             stall_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic [1:0]       fwd_a_d,
  output logic [1:0]       fwd_b_d,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [2:0]       state_o,
  output logic [31:0]      stall_cnt
);

  localparam bit DRAIN_EN = (DRAIN_CYCLES > 0);
  localparam int CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_EN ? DRAIN_CYCLES - 1 : 0);

  state_t        state, next_state;
  logic [CW-1:0] drain_cnt;
  logic          load_use, cp0_wr_m, drain_req;
  logic [8:0]    ctrl;
  logic [1:0]    fa_d, fb_d, fa_e, fb_e;

  function automatic logic hit(input logic [REG_W-1:0] src, input logic we,
                               input logic [REG_W-1:0] dst);
    return we && dst == src && src != '0;
  endfunction

  assign load_use = (memread_e && (hit(rs_d, regwrite_e, wreg_e) || hit(rt_d, regwrite_e, wreg_e)))
                 || (branch_d && memread_m &&
                     (hit(rs_d, regwrite_m, wreg_m) || hit(rt_d, regwrite_m, wreg_m)));

  assign cp0_wr_m  = regwrite_m && wreg_m[REG_W-1:REG_W-2] == CP0_PREFIX;
  assign drain_req = DRAIN_EN && ((state == ALU_WAIT)
                               || (cp0_wr_m && state != DRAIN)
                               || (state == DRAIN && drain_cnt != '0));

  always_comb begin
    next_state = RUN;
    if (exc_req && (if_stall || mem_stall)) next_state = EXC_WAIT;
    else if (exc_req)                       next_state = EXC;
    else if (mem_stall)                     next_state = MEM_WAIT;
    else if (load_use)                      next_state = LOAD_USE;
    else if (alu_busy)                      next_state = ALU_WAIT;
    else if (drain_req)                     next_state = DRAIN;
    else if (if_stall)                      next_state = FETCH_WAIT;
  end

  // Leaving DRAIN for any reason discards the remaining count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != DRAIN)  drain_cnt <= '0;
      else if (state != DRAIN)  drain_cnt <= DRAIN_LOAD;
      else                      drain_cnt <= drain_cnt - CW'(1);
    end
  end

  hazard_fwd_unit #(.REG_W(REG_W), .SEL_NEAR(2'b01), .SEL_FAR(2'b10)) u_fwd_d (
    .rs(rs_d), .rt(rt_d),
    .near_tag(wreg_e), .near_we(regwrite_e), .near_ld(memread_e),
    .far_tag(wreg_m),  .far_we(regwrite_m),  .far_ld(memread_m),
    .fwd_a(fa_d), .fwd_b(fb_d)
  );

  hazard_fwd_unit #(.REG_W(REG_W), .SEL_NEAR(2'b10), .SEL_FAR(2'b01)) u_fwd_e (
    .rs(rs_e), .rt(rt_e),
    .near_tag(wreg_m), .near_we(regwrite_m), .near_ld(memread_m),
    .far_tag(wreg_w),  .far_we(regwrite_w),  .far_ld(1'b0),
    .fwd_a(fa_e), .fwd_b(fb_e)
  );

  assign ctrl = rst ? 9'b0 : ctrl_of(next_state);
  assign {stall_f, stall_d, stall_e, stall_m, stall_w,
          flush_d, flush_e, flush_m, flush_w} = ctrl;

  assign fwd_a_d = rst ? 2'b00 : fa_d;
  assign fwd_b_d = rst ? 2'b00 : fb_d;
  assign fwd_a_e = rst ? 2'b00 : fa_e;
  assign fwd_b_e = rst ? 2'b00 : fb_e;
  assign state_o = state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   perf_q <= '0;
    else if (stall_f && perf_q != 32'hFFFF_FFFF) perf_q <= perf_q + 32'd1;
  end
  assign stall_cnt = perf_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// Directed bench for hazard_ctrl_v2; a second instance with DRAIN_CYCLES=0 covers the no-drain build.
module tb_hazard_ctrl_v2;
  import hazard_ctrl_v2_pkg::*;

  localparam int REG_W = 7;
`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] EXP_CNT_LU = 32'd1;
`else
  localparam logic [31:0] EXP_CNT_LU = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic exc_req, if_stall, mem_stall, alu_busy, branch_d;
  logic [REG_W-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
  logic regwrite_e, regwrite_m, regwrite_w, memread_e, memread_m;

  logic sf, sd, se, sm, sw, fd, fe, fm, fw;
  logic [1:0] fad, fbd, fae, fbe;
  logic [2:0] st;
  logic [31:0] scnt;
  logic sf0, sd0, se0, sm0, sw0, fd0, fe0, fm0, fw0;
  logic [1:0] fad0, fbd0, fae0, fbe0;
  logic [2:0] st0;
  logic [31:0] scnt0;

  logic [8:0] ctrl, ctrl0;
  assign ctrl  = {sf, sd, se, sm, sw, fd, fe, fm, fw};
  assign ctrl0 = {sf0, sd0, se0, sm0, sw0, fd0, fe0, fm0, fw0};

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_v2 #(.REG_W(REG_W), .DRAIN_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .if_stall(if_stall), .mem_stall(mem_stall),
    .alu_busy(alu_busy), .branch_d(branch_d), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w), .regwrite_e(regwrite_e),
    .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .memread_e(memread_e), .memread_m(memread_m),
    .stall_f(sf), .stall_d(sd), .stall_e(se), .stall_m(sm), .stall_w(sw),
    .flush_d(fd), .flush_e(fe), .flush_m(fm), .flush_w(fw),
    .fwd_a_d(fad), .fwd_b_d(fbd), .fwd_a_e(fae), .fwd_b_e(fbe),
    .state_o(st), .stall_cnt(scnt)
  );

  hazard_ctrl_v2 #(.REG_W(REG_W), .DRAIN_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .exc_req(exc_req), .if_stall(if_stall), .mem_stall(mem_stall),
    .alu_busy(alu_busy), .branch_d(branch_d), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w), .regwrite_e(regwrite_e),
    .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .memread_e(memread_e), .memread_m(memread_m),
    .stall_f(sf0), .stall_d(sd0), .stall_e(se0), .stall_m(sm0), .stall_w(sw0),
    .flush_d(fd0), .flush_e(fe0), .flush_m(fm0), .flush_w(fw0),
    .fwd_a_d(fad0), .fwd_b_d(fbd0), .fwd_a_e(fae0), .fwd_b_e(fbe0),
    .state_o(st0), .stall_cnt(scnt0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    exc_req = 0; if_stall = 0; mem_stall = 0; alu_busy = 0; branch_d = 0;
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; wreg_e = 0; wreg_m = 0; wreg_w = 0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0; memread_e = 0; memread_m = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    // reset: outputs forced quiet even with live requests
    exc_req = 1; rs_e = 3; regwrite_m = 1; wreg_m = 3;
    #2;
    chk("rst_ctrl", {23'd0, ctrl}, 32'h000);
    chk("rst_state", {29'd0, st}, 32'd0);
    chk("rst_fwd", {24'd0, fad, fbd, fae, fbe}, 32'h00);
    chk("rst_cnt", scnt, 32'd0);
    tick(); tick();
    clear_inputs();
    rst = 0;
    #1;
    chk("run_ctrl", {23'd0, ctrl}, 32'h000);

    // load-use
    memread_e = 1; regwrite_e = 1; wreg_e = 5; rs_d = 5;
    #1;
    chk("lu_ctrl", {23'd0, ctrl}, 32'h184);
    tick();
    chk("lu_state", {29'd0, st}, 32'd4);
    chk("lu_cnt", scnt, EXP_CNT_LU);
    memread_e = 0; regwrite_e = 0; memread_m = 1; regwrite_m = 1; wreg_m = 5;
    #1;
    chk("lu_rel_ctrl", {23'd0, ctrl}, 32'h000);
    chk("lu_rel_fwd", {30'd0, fad}, 32'd0);
    tick();
    chk("lu_rel_state", {29'd0, st}, 32'd0);

    // forwarding selects
    clear_inputs();
    rs_d = 5; regwrite_e = 1; wreg_e = 5; rt_d = 9; regwrite_m = 1; wreg_m = 9;
    #1;
    chk("fwd_d_e", {30'd0, fad}, 32'd1);
    chk("fwd_d_m", {30'd0, fbd}, 32'd2);
    clear_inputs();
    rs_e = 3; rt_e = 4; regwrite_m = 1; wreg_m = 3; regwrite_w = 1; wreg_w = 4;
    #1;
    chk("fwd_e_m", {30'd0, fae}, 32'd2);
    chk("fwd_e_w", {30'd0, fbe}, 32'd1);
    wreg_w = 3;
    #1;
    chk("fwd_e_prio", {30'd0, fae}, 32'd2);
    rs_e = 0; wreg_m = 0; wreg_w = 0;
    #1;
    chk("fwd_zero", {28'd0, fae, fbe}, 32'd0);

    // branch after load
    clear_inputs();
    branch_d = 1; memread_m = 1; regwrite_m = 1; wreg_m = 8; rt_d = 8;
    #1;
    chk("br_lu_ctrl", {23'd0, ctrl}, 32'h184);
    tick();
    chk("br_lu_state", {29'd0, st}, 32'd4);
    memread_m = 0;
    #1;
    chk("br_fwd_ctrl", {23'd0, ctrl}, 32'h000);
    chk("br_fwd_b", {30'd0, fbd}, 32'd2);
    tick();

    // ALU busy then drain
    clear_inputs();
    alu_busy = 1;
    #1;
    chk("alu_ctrl", {23'd0, ctrl}, 32'h1C2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alu_state", {29'd0, st}, 32'd5);
    end
    alu_busy = 0;
    #1;
    chk("drain_ctrl", {23'd0, ctrl}, 32'h184);
    chk("nodrain_ctrl", {23'd0, ctrl0}, 32'h000);
    tick();
    chk("drain1_state", {29'd0, st}, 32'd6);
    chk("nodrain_state", {29'd0, st0}, 32'd0);
    chk("drain1_ctrl", {23'd0, ctrl}, 32'h184);
    tick();
    chk("drain2_state", {29'd0, st}, 32'd6);
    chk("drain2_ctrl", {23'd0, ctrl}, 32'h000);
    tick();
    chk("drain_done", {29'd0, st}, 32'd0);

    // CP0 write drain, preempted by exception
    regwrite_m = 1; wreg_m = 7'b0101100;
    #1;
    chk("cp0_ctrl", {23'd0, ctrl}, 32'h184);
    chk("cp0_nodrain", {23'd0, ctrl0}, 32'h000);
    tick();
    chk("cp0_state", {29'd0, st}, 32'd6);
    regwrite_m = 0; wreg_m = 0; exc_req = 1;
    #1;
    chk("cp0_exc_ctrl", {23'd0, ctrl}, 32'h1FF);
    tick();
    chk("cp0_exc_state", {29'd0, st}, 32'd1);
    exc_req = 0;
    #1;
    chk("drain_discard", {23'd0, ctrl}, 32'h000);
    tick();
    chk("post_exc_state", {29'd0, st}, 32'd0);

    // exception during memory wait
    exc_req = 1; mem_stall = 1;
    #1;
    chk("excw_ctrl", {23'd0, ctrl}, 32'h1FE);
    tick();
    chk("excw_state", {29'd0, st}, 32'd2);
    mem_stall = 0;
    #1;
    chk("excw_exc_ctrl", {23'd0, ctrl}, 32'h1FF);
    tick();
    chk("excw_exc_state", {29'd0, st}, 32'd1);
    clear_inputs();
    tick();

    // memory wait beats ALU busy; fetch wait alone
    mem_stall = 1; alu_busy = 1;
    #1;
    chk("mem_prio", {23'd0, ctrl}, 32'h1E1);
    clear_inputs();
    if_stall = 1;
    #1;
    chk("fetch_ctrl", {23'd0, ctrl}, 32'h108);
    clear_inputs();
    tick();

    // async reset mid ALU_WAIT
    alu_busy = 1;
    tick();
    chk("pre_rst_state", {29'd0, st}, 32'd5);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_ctrl", {23'd0, ctrl}, 32'h000);
    chk("mid_rst_state", {29'd0, st}, 32'd0);
    chk("mid_rst_cnt", scnt, 32'd0);
    alu_busy = 0;
    tick();
    rst = 0;
    tick();
    chk("post_rst_state", {29'd0, st}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_v2.md
# hazard_ctrl_v2

Parametrised successor hazard unit for the 5-stage (F/D/E/M/W) MIPS pipeline. It sits beside the datapath and issues per-stage stall/flush controls and D/E-stage forwarding selects. It replaces the hard-wired two-bubble sequence with a programmable drain counter, and separates load-use, branch-operand, ALU-busy, memory-busy and exception handling into a prioritised state machine.

## Interface
Parameters:
- REG_W, 7, register tag width; tag 0 is the zero register; tags with top two bits 2'b01 are CP0 registers.
- DRAIN_CYCLES, 2, bubbles inserted after an ALU multi-cycle op completes or a CP0 write reaches M; 0 disables draining.

Ports (clock `clk`, reset `rst`: one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- exc_req  in  1  exception/ERET flush request
- if_stall, mem_stall  in  1 each  fetch / data memory busy
- alu_busy  in  1  multi-cycle mul/div in E not done
- branch_d  in  1  instruction in D is a branch/jump-register
- rs_d, rt_d, rs_e, rt_e  in  REG_W  source tags
- wreg_e, wreg_m, wreg_w  in  REG_W  destination tags
- regwrite_e, regwrite_m, regwrite_w  in  1  write-enable per stage
- memread_e, memread_m  in  1  load in stage
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1
- flush_d, flush_e, flush_m, flush_w  out  1
- fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e  out  2  forwarding selects
- state_o  out  3  current state (debug)
- stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Match(x, s) := regwrite_s & wreg_s==x & x!=0.
- fwd_*_d: 01 if Match from E & !memread_e; else 10 if Match from M & !memread_m; else 00.
- fwd_*_e: 10 if Match from M & !memread_m; else 01 if Match from W; else 00.
- next_state priority (highest first):
  - EXC_WAIT: exc_req & (if_stall|mem_stall)
  - EXC: exc_req
  - MEM_WAIT: mem_stall
  - LOAD_USE: (memread_e & Match(rs_d|rt_d, E)) or (branch_d & memread_m & Match(rs_d|rt_d, M))
  - ALU_WAIT: alu_busy
  - DRAIN: entered when state==ALU_WAIT & !alu_busy, or CP0 write in M (regwrite_m & wreg_m[REG_W-1:REG_W-2]==2'b01) while state!=DRAIN; held while drain count!=0. Suppressed when DRAIN_CYCLES==0.
  - FETCH_WAIT: if_stall
  - RUN: otherwise
- Output decode (stall FDEMW / flush DEMW):
  - RUN 00000/0000
  - EXC 11111/1111
  - EXC_WAIT 11111/1110
  - MEM_WAIT 11110/0001
  - LOAD_USE 11000/0100
  - ALU_WAIT 11100/0010
  - DRAIN 11000/0100
  - FETCH_WAIT 10000/1000
- A higher-priority event preempts DRAIN; the remaining count is discarded, not resumed.

## Timing
- Controls and forwarding selects decode combinationally from next_state and inputs: they respond in the same cycle as the request.
- The state register and drain counter update on posedge clk; async rst forces RUN, count 0, stall_cnt 0.
- During rst, all stall/flush outputs are 0 and all fwd outputs are 00.
- Drain counter loads DRAIN_CYCLES-1 on DRAIN entry and decrements each DRAIN cycle. Exactly DRAIN_CYCLES consecutive DRAIN cycles occur absent preemption.
- Counter width is $clog2(DRAIN_CYCLES+1), minimum 1.
- Reset asserted mid-drain or mid-wait aborts immediately; the first cycle after release is RUN.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt increments on every cycle in which stall_f=1, saturates at 32'hFFFF_FFFF, and is cleared by rst.
- HAZARD_PERF_CNT_EN undefined: stall_cnt is tied to 0 and no counter flops are synthesised.

## Structure
- A shared package holds the state enum (RUN, EXC, EXC_WAIT, MEM_WAIT, LOAD_USE, ALU_WAIT, DRAIN, FETCH_WAIT; 3-bit), the 9-bit control-vector constants per state, and the CP0 tag prefix 2'b01.
- One sub-module, hazard_fwd_unit, holds the purely combinational forwarding logic and is instantiated twice (D and E stage selects).

## Test plan
- Load-use: memread_e=1, regwrite_e=1, wreg_e=5, rs_d=5 -> one cycle LOAD_USE (stall_f=stall_d=1, flush_e=1), then RUN when the load moves to M.
- Branch after load: branch_d=1, memread_m=1, wreg_m=8, rt_d=8 -> LOAD_USE; with memread_m=0 instead -> fwd_b_d=10 and no stall.
- ALU drain: alu_busy high 4 cycles, DRAIN_CYCLES=2 -> 4 ALU_WAIT cycles (flush_m=1), then exactly 2 DRAIN cycles, then RUN; with DRAIN_CYCLES=0 -> RUN directly.
- CP0 write: regwrite_m=1, wreg_m=7'b0101100 -> 2 DRAIN cycles; exc_req in the 1st drain cycle -> EXC (all 9 controls 1), drain abandoned.
- Exception during memory wait: exc_req=1, mem_stall=1 -> controls 11111/1110; mem_stall drops -> EXC next cycle.
- Reset mid-ALU_WAIT: assert rst asynchronously -> all controls 0 immediately, state_o=RUN; with HAZARD_PERF_CNT_EN, stall_cnt=0.
